// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the next PC, talks to instruction memory and fills IF/ID.
// Optional fetch statistics counter is enabled by defining FETCH_STATS_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] curr_pc,
    output logic [15:0] new_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] buf_r, buf_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] pc2_r, pc2_s;
    logic        valid_r, valid_s;
    logic        halted_r, halted_s;
    logic        load_s;
    logic [15:0] load_word_s;
    logic [15:0] pc_plus2_s;

    assign imem_addr     = curr_pc;
    assign ifid_instr    = instr_r;
    assign ifid_pc_plus2 = pc2_r;
    assign ifid_valid    = valid_r;
    assign halted        = halted_r;

    // Next-state, next-PC and IF/ID update selection.
    always_comb begin
        state_s     = state_r;
        buf_s       = buf_r;
        instr_s     = instr_r;
        pc2_s       = pc2_r;
        valid_s     = valid_r;
        halted_s    = halted_r;
        load_s      = 1'b0;
        load_word_s = buf_r;
        pc_plus2_s  = curr_pc + 16'd2;
        new_pc      = curr_pc;
        imem_req    = (state_r == S_FETCH);

        if (redirect) begin
            // Redirect wins over stall and drops any response arriving this cycle.
            new_pc   = redirect_pc;
            valid_s  = 1'b0;
            buf_s    = 16'h0000;
            halted_s = 1'b0;
            state_s  = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            load_s      = 1'b1;
                            load_word_s = imem_rdata;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end else begin
                        if (imem_ready) begin
                            buf_s   = imem_rdata;
                            state_s = S_BUF;
                        end else begin
                            state_s = S_FETCH;
                        end
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        load_s      = 1'b1;
                        load_word_s = buf_r;
                    end else begin
                        state_s = S_BUF;
                    end
                end
                S_HALT: begin
                    if (!stall) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                default: begin
                    state_s = S_FETCH;
                end
            endcase
        end

        if (load_s) begin
            instr_s = load_word_s;
            pc2_s   = pc_plus2_s;
            valid_s = 1'b1;
            buf_s   = 16'h0000;
            if (load_word_s[15:12] == 4'hF) begin
                halted_s = 1'b1;
                state_s  = S_HALT;
                new_pc   = curr_pc;
            end else begin
                state_s  = S_FETCH;
                new_pc   = pc_plus2_s;
            end
        end else begin
            pc2_s = pc2_r;
        end
    end

    // State, buffer and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_FETCH;
            buf_r    <= 16'h0000;
            instr_r  <= 16'h0000;
            pc2_r    <= 16'h0000;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            buf_r    <= buf_s;
            instr_r  <= instr_s;
            pc2_r    <= pc2_s;
            valid_r  <= valid_s;
            halted_r <= halted_s;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] count_r;

    assign fetch_count = count_r;

    // Counts every valid load into IF/ID, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'h0000;
        end else if (load_s) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  global clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 curr_pc  input  16  current program counter from PC register.
REQ-004 new_pc  output  16  next PC, combinational; the PC register writes it every cycle.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  16  instruction address, equal to curr_pc.
REQ-007 imem_rdata  input  16  instruction word, valid when imem_ready=1.
REQ-008 imem_ready  input  1  memory response strobe for the current imem_addr.
REQ-009 stall  input  1  hazard-unit hold of IF/ID.
REQ-010 redirect  input  1  taken branch/jump from ID.
REQ-011 redirect_pc  input  16  branch target.
REQ-012 ifid_instr  output  16  registered IF/ID instruction.
REQ-013 ifid_pc_plus2  output  16  registered curr_pc+2 of that instruction.
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-015 halted  output  1  HLT fetched; fetch frozen.

Function
REQ-016 Three states SHALL exist: FETCH, BUF, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=curr_pc.
REQ-018 FETCH, imem_ready=0, stall=0, redirect=0: new_pc=curr_pc, ifid_valid<=0, other IF/ID fields hold.
REQ-019 FETCH, imem_ready=1, stall=0, redirect=0: ifid_instr<=imem_rdata, ifid_pc_plus2<=curr_pc+2, ifid_valid<=1, new_pc=curr_pc+2.
REQ-020 FETCH, imem_ready=1, stall=1, redirect=0: imem_rdata captured in internal buffer, IF/ID holds, new_pc=curr_pc, next state BUF.
REQ-021 FETCH, imem_ready=0, stall=1: IF/ID holds, new_pc=curr_pc, state FETCH.
REQ-022 BUF: imem_req=0; new_pc=curr_pc while stall=1; when stall=0, IF/ID loads buffer, curr_pc+2 and valid=1, new_pc=curr_pc+2, next state FETCH.
REQ-023 An instruction with bits [15:12]=4'hF (HLT), when loaded into IF/ID, SHALL set new_pc=curr_pc, halted<=1, next state HALT (from FETCH or BUF).
REQ-024 HALT: imem_req=0, new_pc=curr_pc, ifid_valid<=0 unless stall=1 (then IF/ID holds), halted stays 1.
REQ-025 redirect=1 SHALL override stall and every state: new_pc=redirect_pc, ifid_valid<=0, buffer discarded, halted<=0, next state FETCH; any same-cycle imem response is dropped.
REQ-026 curr_pc+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-027 imem_addr may change while imem_ready=0; memory restarts the access, no response is owed for the old address.

Reset
REQ-028 rst=1 SHALL asynchronously force state FETCH, ifid_instr=0, ifid_pc_plus2=0, ifid_valid=0, halted=0, buffer cleared, fetch_count=0.
REQ-029 Reset mid-access or in BUF/HALT SHALL discard all pending data; first fetch after release uses curr_pc.

Configuration
REQ-030 With FETCH_STATS_EN defined: output fetch_count (16 bits) increments by 1 each cycle IF/ID loads a valid instruction, wraps 16'hFFFF -> 0, cleared by rst.
REQ-031 Without FETCH_STATS_EN: port fetch_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 curr_pc=16'h0000, imem_ready=1 every cycle, rdata 16'h1234 -> new_pc=16'h0002, next cycle ifid_instr=16'h1234, ifid_pc_plus2=16'h0002, ifid_valid=1.
REQ-033 imem_ready=0 for 3 cycles at curr_pc=16'h0010 -> new_pc=16'h0010 held, ifid_valid=0 three cycles, then valid on ready.
REQ-034 ready=1 with stall=1 for 2 cycles, rdata 16'hA5A5 -> state BUF, imem_req=0; on stall release ifid_instr=16'hA5A5, new_pc=curr_pc+2.
REQ-035 rdata 16'hF000 at curr_pc=16'h0020 -> halted=1, new_pc=16'h0020 thereafter; redirect=1 with redirect_pc=16'h0040 -> halted=0, new_pc=16'h0040, ifid_valid=0.
REQ-036 curr_pc=16'hFFFE, ready=1 -> new_pc=16'h0000, ifid_pc_plus2=16'h0000; rst pulse mid-BUF -> all outputs reset values, fetch_count=0 (FETCH_STATS_EN).
